ipgen_master_read_arbiter: RTL and testbench

Round-robin arbiter that shares a single burst read channel of the master memory port (`ipgen_master_memory` ar/r channels) between `NUM_PORTS` requesters inside a userlogic block. It accepts one read request, issues it on the master address channel, and routes the returned beats to the winning requester until `rlast`. It then re-arbitrates. Only one burst is outstanding at a time.

---
 rtl/ipgen_master_read_arbiter.sv | 152 +++++++++++++++
 tb/tb_ipgen_master_read_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipgen_master_read_arbiter.sv
// Round-robin arbiter sharing one burst read channel (ar/r) of the master
// memory port between NUM_PORTS requesters; one burst outstanding at a time.
module ipgen_master_read_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_PORTS-1:0]            req_arvalid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_PORTS*8-1:0]          req_arlen,
  output logic [NUM_PORTS-1:0]            req_arready,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic                            req_rlast,
  output logic [NUM_PORTS-1:0]            req_rvalid,
  input  logic [NUM_PORTS-1:0]            req_rready,
  output logic                            m_arvalid,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [7:0]                      m_arlen,
  input  logic                            m_arready,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic                            m_rlast,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_q, state_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [NUM_PORTS-1:0]    arready_q, arready_d;
  logic                    m_arvalid_q, m_arvalid_d;
  logic [ADDR_WIDTH-1:0]   m_araddr_q, m_araddr_d;
  logic [7:0]              m_arlen_q, m_arlen_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        widx_q, widx_d;
  logic [8:0]              beat_cnt_q, beat_cnt_d;

  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [NUM_PORTS-1:0]    win_onehot;
  logic [IDX_W:0]          cand;
  logic [IDX_W-1:0]        ptr_inc;

  // Scan from the pointer upward with wrap; first requesting port wins.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (!win_found && req_arvalid[cand[IDX_W-1:0]]) begin
        win_found                      = 1'b1;
        win_idx                        = cand[IDX_W-1:0];
        win_onehot[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

  always_comb begin
    if (widx_q == IDX_W'(NUM_PORTS - 1)) ptr_inc = '0;
    else                                 ptr_inc = widx_q + IDX_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    arready_d   = '0;
    m_arvalid_d = m_arvalid_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    ptr_d       = ptr_q;
    widx_d      = widx_q;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = ADDR;
          grant_d     = win_onehot;
          arready_d   = win_onehot;
          m_arvalid_d = 1'b1;
          m_araddr_d  = req_araddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          m_arlen_d   = req_arlen[win_idx*8 +: 8];
          widx_d      = win_idx;
        end
      end
      ADDR: begin
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          beat_cnt_d  = '0;
          state_d     = DATA;
        end
      end
      DATA: begin
        // Only rlast ends the burst; the counter is observational and saturates.
        if (m_rvalid && m_rready) begin
          if (beat_cnt_q != 9'd256) beat_cnt_d = beat_cnt_q + 9'd1;
          if (m_rlast) begin
            ptr_d   = ptr_inc;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      arready_q   <= '0;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      ptr_q       <= '0;
      widx_q      <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      arready_q   <= arready_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      ptr_q       <= ptr_d;
      widx_q      <= widx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Return path is combinational so beats pass with no added latency.
  assign req_rvalid  = grant_q & {NUM_PORTS{m_rvalid}};
  assign m_rready    = |(grant_q & req_rready);
  assign req_rdata   = m_rdata;
  assign req_rlast   = m_rlast;
  assign req_arready = arready_q;
  assign m_arvalid   = m_arvalid_q;
  assign m_araddr    = m_araddr_q;
  assign m_arlen     = m_arlen_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ipgen_master_read_arbiter.sv
// Scoreboard bench for ipgen_master_read_arbiter: expected grants and beats are
// queued by the stimulus and popped by a monitor when the DUT presents them.
module tb_ipgen_master_read_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [NP-1:0]     req_arvalid;
  logic [NP*AW-1:0]  req_araddr;
  logic [NP*8-1:0]   req_arlen;
  logic [NP-1:0]     req_arready;
  logic [DW-1:0]     req_rdata;
  logic              req_rlast;
  logic [NP-1:0]     req_rvalid;
  logic [NP-1:0]     req_rready;
  logic              m_arvalid;
  logic [AW-1:0]     m_araddr;
  logic [7:0]        m_arlen;
  logic              m_arready;
  logic [DW-1:0]     m_rdata;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic [NP-1:0]     grant;
  logic              busy;

  ipgen_master_read_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rlast(req_rlast),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { int port; logic [AW-1:0] addr; logic [7:0] len; } ar_item_t;
  typedef struct { int port; logic [DW-1:0] data; logic last; } r_item_t;

  ar_item_t exp_ar[$];
  r_item_t  exp_r[$];

  int n_tests = 0;
  int n_fail  = 0;
  int grants_got[NP] = '{default: 0};
  int req_total[NP]  = '{default: 0};
  logic [AW-1:0] addr_t[NP] = '{default: '0};
  logic [7:0]    len_t[NP]  = '{default: '0};
  int beats_seen = 0;
  int ar_delay   = 0;
  bit bp_en      = 1'b0;
  bit gap_en     = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(input int p, input logic [AW-1:0] a, input logic [7:0] l);
    ar_item_t e;
    r_item_t  r;
    e.port = p; e.addr = a; e.len = l;
    exp_ar.push_back(e);
    for (int k = 0; k <= int'(l); k++) begin
      r.port = p; r.data = a + DW'(k); r.last = (k == int'(l));
      exp_r.push_back(r);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [7:0] l, input int n);
    addr_t[p]    = a;
    len_t[p]     = l;
    req_total[p] = req_total[p] + n;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"},     grant,       0);
    chk({tag, "_arready"},   req_arready, 0);
    chk({tag, "_m_arvalid"}, m_arvalid,   0);
    chk({tag, "_m_araddr"},  m_araddr,    0);
    chk({tag, "_m_arlen"},   m_arlen,     0);
    chk({tag, "_busy"},      busy,        0);
    chk({tag, "_rvalid"},    req_rvalid,  0);
    chk({tag, "_m_rready"},  m_rready,    0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
  endtask

  task automatic wait_beats(input int target);
    int t;
    for (t = 0; t < 500; t++) begin
      @(posedge CLK);
      if (beats_seen >= target) break;
    end
    chk("beat_wait_in_time", (t < 500), 1);
  endtask

  task automatic wait_done(input string tag);
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge CLK); #1;
      if (exp_ar.size() == 0 && exp_r.size() == 0 && !busy) break;
    end
    chk({tag, "_drained_in_time"}, (t < 3000), 1);
    chk({tag, "_grant_idle"}, grant, 0);
  endtask

  // Requesters: port i keeps arvalid high until it has collected its grants.
  initial begin : requester
    req_arvalid = '0;
    req_araddr  = '0;
    req_arlen   = '0;
    forever begin
      @(negedge CLK); #1;
      for (int i = 0; i < NP; i++) begin
        req_arvalid[i]          = (grants_got[i] < req_total[i]);
        req_araddr[i*AW +: AW]  = addr_t[i];
        req_arlen[i*8 +: 8]     = len_t[i];
      end
    end
  end

  // Master memory model: beat k of a burst carries address + k.
  initial begin : master
    bit ar_hs, r_hs, mb_busy;
    int mb_idx, mb_len, ar_cnt;
    logic [AW-1:0] mb_addr;
    mb_busy = 1'b0; mb_idx = 0; mb_len = 0; ar_cnt = 0; mb_addr = '0;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
    forever begin
      @(negedge CLK);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      if (r_hs) begin
        if (m_rlast) mb_busy = 1'b0;
        else         mb_idx++;
      end
      if (ar_hs) begin
        mb_busy = 1'b1; mb_idx = 0; mb_len = int'(m_arlen); mb_addr = m_araddr; ar_cnt = 0;
      end else if (m_arvalid) begin
        ar_cnt++;
      end
      if (!RST) begin mb_busy = 1'b0; ar_cnt = 0; end
      @(posedge CLK); #1;
      m_arready = (ar_cnt >= ar_delay);
      m_rvalid  = mb_busy;
      m_rdata   = mb_addr + DW'(mb_idx);
      m_rlast   = mb_busy && (mb_idx == mb_len);
    end
  end

  initial begin : monitor
    logic [NP-1:0] prev_ard;
    bit in_burst, prev_stall, seen_busy;
    int owner, ar_wait, low_run;
    logic [AW-1:0] cap_a;
    logic [7:0] cap_l;
    ar_item_t e;
    r_item_t r;
    prev_ard = '0; in_burst = 0; prev_stall = 0; seen_busy = 0;
    owner = 0; ar_wait = 0; low_run = 0; cap_a = '0; cap_l = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        in_burst = 0; prev_ard = '0; prev_stall = 0; ar_wait = 0; low_run = 0; seen_busy = 0;
      end else begin
        if (req_arready != '0) begin
          chk("arready_single_pulse", prev_ard, 0);
          for (int i = 0; i < NP; i++) if (req_arready[i]) grants_got[i]++;
          if (exp_ar.size() == 0) begin
            chk("unexpected_grant", req_arready, 0);
          end else begin
            e = exp_ar.pop_front();
            chk("arready_port",       req_arready, 64'(1) << e.port);
            chk("grant_onehot",       grant,       64'(1) << e.port);
            chk("m_arvalid_on_grant", m_arvalid,   1);
            chk("m_araddr",           m_araddr,    e.addr);
            chk("m_arlen",            m_arlen,     e.len);
            owner = e.port; cap_a = e.addr; cap_l = e.len; in_burst = 1; ar_wait = 0;
          end
        end else if (m_arvalid) begin
          chk("m_araddr_stable", m_araddr, cap_a);
          chk("m_arlen_stable",  m_arlen,  cap_l);
        end
        if (prev_stall) chk("m_arvalid_held", m_arvalid, 1);
        if (m_arvalid && m_arready && bp_en) chk("ar_wait_cycles", ar_wait, 5);
        prev_stall = m_arvalid && !m_arready;
        if (prev_stall) ar_wait++;

        if (in_burst && m_rvalid) begin
          chk("req_rvalid_owner_only",  req_rvalid, 64'(1) << owner);
          chk("m_rready_follows_owner", m_rready,   req_rready[owner]);
        end
        if (m_rvalid && m_rready) begin
          if (exp_r.size() == 0) begin
            chk("unexpected_beat", m_rvalid, 0);
          end else begin
            r = exp_r.pop_front();
            chk("beat_routed", req_rvalid, 64'(1) << r.port);
            chk("req_rdata",   req_rdata,  r.data);
            chk("req_rlast",   req_rlast,  r.last);
            beats_seen++;
          end
          if (m_rlast) in_burst = 0;
        end

        if (!gap_en) begin
          low_run = 0; seen_busy = 0;
        end else if (busy) begin
          if (seen_busy && low_run > 0) chk("idle_gap_cycles", low_run, 1);
          low_run = 0; seen_busy = 1;
        end else begin
          low_run++;
        end
        prev_ard = req_arready;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b0;
    req_rready = '1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_vals("por");
    @(posedge CLK); #1 RST = 1'b1;

    // Single burst from port 1
    push_burst(1, 32'h100, 8'd15);
    set_port(1, 32'h100, 8'd15, 1);
    wait_done("single");

    // Ports 0 and 2 together, two bursts each: 0,2,0,2 with one idle cycle between
    do_reset();
    gap_en = 1'b1;
    push_burst(0, 32'h200, 8'd3);
    push_burst(2, 32'h400, 8'd3);
    push_burst(0, 32'h200, 8'd3);
    push_burst(2, 32'h400, 8'd3);
    set_port(0, 32'h200, 8'd3, 2);
    set_port(2, 32'h400, 8'd3, 2);
    wait_done("simul");
    gap_en = 1'b0;

    // All ports request: rotation 0,1,2,3 then 0,1
    do_reset();
    for (int i = 0; i < NP; i++) push_burst(i, AW'(32'h1000 * (i + 1)), 8'd1);
    push_burst(0, 32'h1000, 8'd1);
    push_burst(1, 32'h2000, 8'd1);
    for (int i = 0; i < NP; i++) set_port(i, AW'(32'h1000 * (i + 1)), 8'd1, (i < 2) ? 2 : 1);
    wait_done("all");

    // Address channel held off for 5 cycles
    ar_delay = 5;
    bp_en    = 1'b1;
    push_burst(3, 32'h300, 8'd2);
    set_port(3, 32'h300, 8'd2, 1);
    wait_done("ar_bp");
    bp_en    = 1'b0;
    ar_delay = 0;

    // Granted port 2 withdraws rready mid-burst while the others keep theirs high
    push_burst(2, 32'h900, 8'd7);
    b0 = beats_seen;
    set_port(2, 32'h900, 8'd7, 1);
    wait_beats(b0 + 3);
    #1 req_rready = 4'b1011;
    repeat (3) @(posedge CLK);
    #1 req_rready = '1;
    wait_done("r_bp");

    // Reset during beat 3 of a 16-beat burst, then ports 1 and 3 contend
    push_burst(2, 32'h500, 8'd0);
    set_port(2, 32'h500, 8'd0, 1);
    wait_done("pre_rst");
    push_burst(1, 32'h600, 8'd15);
    b0 = beats_seen;
    set_port(1, 32'h600, 8'd15, 1);
    wait_beats(b0 + 2);
    #1 RST = 1'b0;
    @(posedge CLK); #1 RST = 1'b1;
    exp_r.delete();
    @(negedge CLK);
    check_reset_vals("mid_rst");
    push_burst(1, 32'h700, 8'd1);
    push_burst(3, 32'h800, 8'd1);
    set_port(1, 32'h700, 8'd1, 1);
    set_port(3, 32'h800, 8'd1, 1);
    wait_done("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
